// File: rtl/tile_scan.sv
// tile_scan: walks one 32x32 tile row by row, waits for the plane
// interpolator to settle, captures the row and streams it out pixel by pixel.
module tile_scan #(
    parameter int IP_LAT   = 1,
    parameter int TILE_DIM = 32
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic [5:0]               tile_x,
    input  logic [5:0]               tile_y,
    output logic [10:0]              x_ps,
    output logic [10:0]              y_ps,
    input  logic [TILE_DIM*32-1:0]   row_in,
    output logic                     pix_valid,
    input  logic                     pix_ready,
    output logic [10:0]              pix_x,
    output logic [10:0]              pix_y,
    output logic [31:0]              pix_val,
    output logic                     pix_last,
    output logic                     busy,
    output logic                     done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETTLE  = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_EMIT    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [2:0] LAT  = 3'(IP_LAT);
    localparam logic [4:0] LAST = 5'(TILE_DIM - 1);

    logic [2:0]               state_q, state_d;
    logic [4:0]               row_q, row_d;
    logic [4:0]               col_q, col_d;
    logic [2:0]               cnt_q, cnt_d;
    logic [10:0]              x_ps_q, x_ps_d;
    logic [10:0]              y_ps_q, y_ps_d;
    logic [TILE_DIM*32-1:0]   row_buf_q, row_buf_d;
    logic                     pix_valid_q, pix_valid_d;
    logic                     pix_last_q, pix_last_d;
    logic [10:0]              pix_x_q, pix_x_d;
    logic [10:0]              pix_y_q, pix_y_d;
    logic [31:0]              pix_val_q, pix_val_d;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        x_ps_d    = x_ps_q;
        y_ps_d    = y_ps_q;
        row_buf_d = row_buf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_ps_d  = {tile_x, 5'd0};
                    y_ps_d  = {tile_y, 5'd0};
                    row_d   = '0;
                    col_d   = '0;
                    cnt_d   = LAT;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                row_buf_d = row_in;
                col_d     = '0;
                state_d   = S_EMIT;
            end
            S_EMIT: begin
                if (pix_ready) begin
                    col_d = col_q + 5'd1;
                    if (col_q == LAST) begin
                        if (row_q == LAST) begin
                            state_d = S_DONE;
                        end else begin
                            row_d   = row_q + 5'd1;
                            y_ps_d  = y_ps_q + 11'd1;
                            cnt_d   = LAT;
                            state_d = S_SETTLE;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pixel outputs are registered from the next-state view, so a stalled
    // pixel simply recomputes the same values and holds.
    always_comb begin
        pix_valid_d = (state_d == S_EMIT);
        pix_last_d  = pix_valid_d && (row_d == LAST) && (col_d == LAST);
        pix_x_d     = x_ps_d + {6'd0, col_d};
        pix_y_d     = y_ps_d;
        pix_val_d   = row_buf_d[{col_d, 5'd0} +: 32];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            cnt_q       <= '0;
            x_ps_q      <= '0;
            y_ps_q      <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            pix_val_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cnt_q       <= cnt_d;
            x_ps_q      <= x_ps_d;
            y_ps_q      <= y_ps_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            pix_val_q   <= pix_val_d;
        end
    end

    // The row buffer is pure datapath; its contents are irrelevant after reset.
    always_ff @(posedge clock) begin
        row_buf_q <= row_buf_d;
    end

    assign x_ps      = x_ps_q;
    assign y_ps      = y_ps_q;
    assign pix_valid = pix_valid_q;
    assign pix_last  = pix_last_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_val   = pix_val_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_tile_scan.sv
// Bench for tile_scan: two instances (IP_LAT 1 and 3) fed by a delayed
// row model, pixel streams compared against a raster-order reference.
module tb_tile_scan;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic [31:0] v;
        logic        last;
        logic [10:0] xps;
        logic [10:0] yps;
    } pix_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        start = 1'b0;
    logic        pix_ready = 1'b0;
    logic        sel = 1'b0;
    logic [5:0]  tile_x = '0;
    logic [5:0]  tile_y = '0;
    logic        start_a, start_b;
    logic [1023:0] row_a, row_b;

    logic [10:0] a_x_ps, a_y_ps, a_pix_x, a_pix_y;
    logic [10:0] b_x_ps, b_y_ps, b_pix_x, b_pix_y;
    logic [31:0] a_pix_val, b_pix_val;
    logic        a_pix_valid, a_pix_last, a_busy, a_done;
    logic        b_pix_valid, b_pix_last, b_busy, b_done;

    logic [10:0] o_x, o_y, o_xps, o_yps;
    logic [31:0] o_val;
    logic        o_valid, o_last, o_busy, o_done;

    logic [31:0] mem [32][32];
    logic [10:0] ya_h;
    logic [10:0] yb_h [3];

    pix_t got[$];
    pix_t stall_pix;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    assign start_a = start & ~sel;
    assign start_b = start & sel;

    tile_scan #(.IP_LAT(1), .TILE_DIM(32)) dut_a (
        .clock(clock), .reset_n(reset_n), .start(start_a),
        .tile_x(tile_x), .tile_y(tile_y),
        .x_ps(a_x_ps), .y_ps(a_y_ps), .row_in(row_a),
        .pix_valid(a_pix_valid), .pix_ready(pix_ready),
        .pix_x(a_pix_x), .pix_y(a_pix_y), .pix_val(a_pix_val),
        .pix_last(a_pix_last), .busy(a_busy), .done(a_done)
    );

    tile_scan #(.IP_LAT(3), .TILE_DIM(32)) dut_b (
        .clock(clock), .reset_n(reset_n), .start(start_b),
        .tile_x(tile_x), .tile_y(tile_y),
        .x_ps(b_x_ps), .y_ps(b_y_ps), .row_in(row_b),
        .pix_valid(b_pix_valid), .pix_ready(pix_ready),
        .pix_x(b_pix_x), .pix_y(b_pix_y), .pix_val(b_pix_val),
        .pix_last(b_pix_last), .busy(b_busy), .done(b_done)
    );

    assign {o_x, o_y, o_val, o_last, o_xps, o_yps, o_valid, o_busy, o_done} = sel ?
        {b_pix_x, b_pix_y, b_pix_val, b_pix_last, b_x_ps, b_y_ps, b_pix_valid, b_busy, b_done} :
        {a_pix_x, a_pix_y, a_pix_val, a_pix_last, a_x_ps, a_y_ps, a_pix_valid, a_busy, a_done};

    // Interpolator model: row_in reflects y_ps as it was IP_LAT cycles ago.
    always @(posedge clock) begin
        ya_h    <= a_y_ps;
        yb_h[0] <= b_y_ps;
        yb_h[1] <= yb_h[0];
        yb_h[2] <= yb_h[1];
    end

    always_comb begin
        row_a = '0;
        row_b = '0;
        for (int k = 0; k < 32; k++) begin
            row_a[32*k +: 32] = mem[ya_h[4:0]][k];
            row_b[32*k +: 32] = mem[yb_h[2][4:0]][k];
        end
    end

    function automatic pix_t model_pix(input int i, input int tx, input int ty);
        pix_t p;
        int r;
        int c;
        r = i / 32;
        c = i % 32;
        p.x    = 11'(tx * 32 + c);
        p.y    = 11'(ty * 32 + r);
        p.v    = mem[r][c];
        p.last = (i == 1023);
        p.xps  = 11'(tx * 32);
        p.yps  = 11'(ty * 32 + r);
        return p;
    endfunction

    task automatic scan_tile(input int tx, input int ty, input int rpct,
                             input int sidx, input int slen, input int abort_idx,
                             input bit poke, output int cyc, output int holds,
                             output int dones, output bit tmo);
        pix_t cur;
        pix_t prev;
        bit   prev_stall;
        bit   stalled;
        bit   fin;
        int   stall_left;
        got.delete();
        cyc = 0; holds = 0; dones = 0; tmo = 0;
        prev = '0; prev_stall = 0; stalled = 0; fin = 0; stall_left = 0;
        @(negedge clock);
        tile_x = 6'(tx);
        tile_y = 6'(ty);
        start = 1'b1;
        pix_ready = 1'b1;
        while (!fin) begin
            @(negedge clock);
            cyc++;
            start = poke && (cyc == 1);
            if (stall_left > 0) begin
                pix_ready = 1'b0;
                stall_left--;
            end else if (!stalled && o_valid && got.size() == sidx) begin
                pix_ready = 1'b0;
                stalled = 1;
                stall_left = slen - 1;
                stall_pix = {o_x, o_y, o_val, o_last, o_xps, o_yps};
            end else begin
                pix_ready = int'($urandom_range(0, 99)) < rpct;
            end
            cur = {o_x, o_y, o_val, o_last, o_xps, o_yps};
            if (prev_stall && cur !== prev) holds++;
            prev_stall = o_valid && !pix_ready;
            prev = cur;
            if (abort_idx >= 0 && o_valid && got.size() == abort_idx) begin
                fin = 1;
            end else begin
                if (o_valid && pix_ready) got.push_back(cur);
                if (o_done) begin
                    dones++;
                    fin = 1;
                    if (poke) start = 1'b1;
                end
                if (cyc >= 8000) begin
                    tmo = 1;
                    fin = 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        #3 reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({a_x_ps, a_y_ps, a_pix_x, a_pix_y, a_pix_val, a_pix_valid,
             a_pix_last, a_busy, a_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_a got %h required 0",
                     {a_x_ps, a_y_ps, a_pix_x, a_pix_y, a_pix_val});
        end
        n_checks++;
        if ({b_x_ps, b_y_ps, b_pix_x, b_pix_y, b_pix_val, b_pix_valid,
             b_pix_last, b_busy, b_done} !== '0) begin
            n_fail++;
            $display("FAIL reset_b got %h required 0",
                     {b_x_ps, b_y_ps, b_pix_x, b_pix_y, b_pix_val});
        end
        reset_n = 1'b1;
        @(negedge clock);
        n_checks++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy got %b%b required 00", a_busy, b_busy);
        end
    endtask

    task automatic test_basic();
        int cyc, holds, dones;
        bit tmo;
        sel = 1'b0;
        for (int r = 0; r < 32; r++)
            for (int k = 0; k < 32; k++) mem[r][k] = 32'(r * 100 + k);
        scan_tile(2, 3, 100, -1, 0, -1, 0, cyc, holds, dones, tmo);
        n_checks++;
        if (tmo || got.size() != 1024) begin
            n_fail++;
            $display("FAIL basic_count got %0d timeout %0b required 1024", got.size(), tmo);
        end
        for (int i = 0; i < got.size() && i < 1024; i++) begin
            n_checks++;
            if (got[i] !== model_pix(i, 2, 3)) begin
                n_fail++;
                $display("FAIL basic_pix[%0d] got %h required %h", i, got[i], model_pix(i, 2, 3));
            end
        end
        n_checks++;
        if (cyc != 32 * 34 + 1 || dones != 1) begin
            n_fail++;
            $display("FAIL basic_cycles got %0d dones %0d required %0d dones 1", cyc, dones, 32 * 34 + 1);
        end
        if (got.size() == 1024) begin
            n_checks++;
            if (got[0].v !== 32'd0 || got[1023].v !== 32'd3131 || got[1023].last !== 1'b1) begin
                n_fail++;
                $display("FAIL basic_ends got %0d %0d last %b required 0 3131 last 1",
                         got[0].v, got[1023].v, got[1023].last);
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc, holds, dones;
        bit tmo;
        sel = 1'b0;
        scan_tile(2, 3, 100, 4 * 32 + 10, 5, -1, 0, cyc, holds, dones, tmo);
        n_checks++;
        if (stall_pix.x !== 11'd74 || stall_pix.y !== 11'd100 || stall_pix.v !== 32'd410) begin
            n_fail++;
            $display("FAIL bp_pixel got x=%0d y=%0d v=%0d required 74 100 410",
                     stall_pix.x, stall_pix.y, stall_pix.v);
        end
        n_checks++;
        if (holds != 0) begin
            n_fail++;
            $display("FAIL bp_hold got %0d changes required 0", holds);
        end
        n_checks++;
        if (tmo || got.size() != 1024) begin
            n_fail++;
            $display("FAIL bp_count got %0d required 1024", got.size());
        end
        for (int i = 0; i < got.size() && i < 1024; i++) begin
            n_checks++;
            if (got[i] !== model_pix(i, 2, 3)) begin
                n_fail++;
                $display("FAIL bp_pix[%0d] got %h required %h", i, got[i], model_pix(i, 2, 3));
            end
        end
        n_checks++;
        if (cyc != 32 * 34 + 1 + 5) begin
            n_fail++;
            $display("FAIL bp_cycles got %0d required %0d", cyc, 32 * 34 + 6);
        end
    endtask

    task automatic test_latency();
        int cyc, holds, dones, tx, ty;
        bit tmo;
        sel = 1'b1;
        tx = int'($urandom_range(0, 63));
        ty = int'($urandom_range(0, 63));
        for (int r = 0; r < 32; r++)
            for (int k = 0; k < 32; k++) mem[r][k] = $urandom();
        scan_tile(tx, ty, 100, -1, 0, -1, 0, cyc, holds, dones, tmo);
        n_checks++;
        if (tmo || got.size() != 1024 || dones != 1) begin
            n_fail++;
            $display("FAIL lat_count got %0d dones %0d required 1024 dones 1", got.size(), dones);
        end
        for (int i = 0; i < got.size() && i < 1024; i++) begin
            n_checks++;
            if (got[i] !== model_pix(i, tx, ty)) begin
                n_fail++;
                $display("FAIL lat_pix[%0d] got %h required %h", i, got[i], model_pix(i, tx, ty));
            end
        end
        n_checks++;
        if (cyc != 32 * 36 + 1) begin
            n_fail++;
            $display("FAIL lat_cycles got %0d required %0d", cyc, 32 * 36 + 1);
        end
    endtask

    task automatic test_random_ready();
        int cyc, holds, dones, tx, ty;
        bit tmo;
        sel = 1'b1;
        tx = int'($urandom_range(0, 63));
        ty = int'($urandom_range(0, 63));
        for (int r = 0; r < 32; r++)
            for (int k = 0; k < 32; k++) mem[r][k] = $urandom();
        scan_tile(tx, ty, 60, -1, 0, -1, 0, cyc, holds, dones, tmo);
        n_checks++;
        if (tmo || got.size() != 1024 || holds != 0 || dones != 1) begin
            n_fail++;
            $display("FAIL rnd_stream got %0d holds %0d dones %0d required 1024 0 1",
                     got.size(), holds, dones);
        end
        for (int i = 0; i < got.size() && i < 1024; i++) begin
            n_checks++;
            if (got[i] !== model_pix(i, tx, ty)) begin
                n_fail++;
                $display("FAIL rnd_pix[%0d] got %h required %h", i, got[i], model_pix(i, tx, ty));
            end
        end
    endtask

    task automatic test_ignored_start();
        int cyc, holds, dones, rose;
        bit tmo;
        sel = 1'b0;
        scan_tile(5, 9, 100, -1, 0, -1, 1, cyc, holds, dones, tmo);
        n_checks++;
        if (tmo || dones != 1 || cyc != 32 * 34 + 1 || got.size() != 1024) begin
            n_fail++;
            $display("FAIL ign_scan got cyc %0d dones %0d count %0d required %0d 1 1024",
                     cyc, dones, got.size(), 32 * 34 + 1);
        end
        @(negedge clock);
        start = 1'b0;
        n_checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL ign_busy_fall got busy %b done %b required 0 0", o_busy, o_done);
        end
        rose = 0;
        repeat (40) begin
            @(negedge clock);
            if (o_busy !== 1'b0) rose++;
        end
        n_checks++;
        if (rose != 0) begin
            n_fail++;
            $display("FAIL ign_restart got %0d busy cycles required 0", rose);
        end
    endtask

    task automatic test_mid_reset();
        int cyc, holds, dones, seen;
        bit tmo;
        sel = 1'b0;
        for (int r = 0; r < 32; r++)
            for (int k = 0; k < 32; k++) mem[r][k] = 32'(r * 100 + k);
        scan_tile(2, 3, 100, -1, 0, 17 * 32 + 5, 0, cyc, holds, dones, tmo);
        n_checks++;
        if (tmo || got.size() != 17 * 32 + 5 || o_x !== 11'd69 || o_y !== 11'd113) begin
            n_fail++;
            $display("FAIL mr_reach got %0d x=%0d y=%0d required %0d 69 113",
                     got.size(), o_x, o_y, 17 * 32 + 5);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({o_x, o_y, o_val, o_last, o_xps, o_yps, o_valid, o_busy, o_done} !== '0) begin
            n_fail++;
            $display("FAIL mr_zero got %h required 0",
                     {o_x, o_y, o_val, o_last, o_xps, o_yps, o_valid, o_busy, o_done});
        end
        seen = 0;
        repeat (3) begin
            @(negedge clock);
            if (o_done !== 1'b0 || o_valid !== 1'b0) seen++;
        end
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clock);
            if (o_done !== 1'b0 || o_busy !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL mr_nodone got %0d active cycles required 0", seen);
        end
        scan_tile(63, 63, 100, -1, 0, -1, 0, cyc, holds, dones, tmo);
        n_checks++;
        if (tmo || got.size() != 1024 || dones != 1) begin
            n_fail++;
            $display("FAIL mr_rescan got %0d dones %0d required 1024 1", got.size(), dones);
        end
        for (int i = 0; i < got.size() && i < 1024; i++) begin
            n_checks++;
            if (got[i] !== model_pix(i, 63, 63)) begin
                n_fail++;
                $display("FAIL mr_pix[%0d] got %h required %h", i, got[i], model_pix(i, 63, 63));
            end
        end
    endtask

    task automatic test_signed();
        int cyc, holds, dones;
        bit tmo;
        sel = 1'b1;
        for (int r = 0; r < 32; r++)
            for (int k = 0; k < 32; k++)
                mem[r][k] = (r % 2 == 1) ? $urandom() :
                            ((k % 2 == 1) ? 32'hFFFF_FFFF : 32'h8000_0000);
        scan_tile(10, 20, 80, -1, 0, -1, 0, cyc, holds, dones, tmo);
        n_checks++;
        if (tmo || got.size() != 1024) begin
            n_fail++;
            $display("FAIL sgn_count got %0d required 1024", got.size());
        end
        for (int i = 0; i < got.size() && i < 1024; i++) begin
            n_checks++;
            if (got[i] !== model_pix(i, 10, 20)) begin
                n_fail++;
                $display("FAIL sgn_pix[%0d] got %h required %h", i, got[i], model_pix(i, 10, 20));
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 32; r++)
            for (int k = 0; k < 32; k++) mem[r][k] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_latency();
        test_random_ready();
        test_ignored_start();
        test_mid_reset();
        test_signed();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
